// File: rtl/sort_pkg.sv
// Shared helpers for the bitonic sorter: network shape, pair indexing and pair direction.
// Elements are packed little-endian: element i occupies bits [i*W +: W].
package sort_pkg;

  localparam int MAX_LOG_N = 5;

  function automatic int elem_lsb(int i, int w);
    return i * w;
  endfunction

  function automatic int stages(int log_n);
    return log_n * (log_n + 1) / 2;
  endfunction

  function automatic int partner(int i, int j);
    return i ^ j;
  endfunction

  // Lower index of the q-th pair in a column whose distance is 2**jlog.
  function automatic int pair_lo(int q, int jlog);
    return ((q >> jlog) << (jlog + 1)) | (q & ((1 << jlog) - 1));
  endfunction

  function automatic logic pair_asc(int i, int k, logic final_merge, logic desc);
    return final_merge ? !desc : ((i & k) == 0);
  endfunction

endpackage

// File: rtl/sort_cas.sv
// Combinational compare-and-swap of two operands; no latency, no flow control.
// asc = 1 routes the smaller value to lo; ties pass straight through.
module sort_cas #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         asc,
  input  logic         is_signed,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  logic a_gt_b;
  logic b_gt_a;
  logic swap;

  assign a_gt_b = is_signed ? ($signed(a) > $signed(b)) : (a > b);
  assign b_gt_a = is_signed ? ($signed(b) > $signed(a)) : (b > a);
  assign swap   = asc ? a_gt_b : b_gt_a;
  assign lo     = swap ? b : a;
  assign hi     = swap ? a : b;

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorter, one register per compare column; latency STAGES edges, 1 vector/cycle.
// A single enable stalls every stage when the output is held; in_ready follows that enable.
module bitonic_sort_pipe
  import sort_pkg::*;
#(
  parameter int LOG_N  = 3,
  parameter int W      = 3,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_desc,
  input  logic [(1<<LOG_N)*W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_desc,
  output logic [(1<<LOG_N)*W-1:0]   out_data
);

  localparam int N      = 1 << LOG_N;
  localparam int STAGES = stages(LOG_N);

  logic [STAGES-1:0][N*W-1:0] stage_dat;
  logic [STAGES-1:0][N*W-1:0] col_in;
  logic [STAGES-1:0][N*W-1:0] col_out;
  logic [STAGES-1:0]          stage_vld;
  logic [STAGES-1:0]          stage_desc;
  logic [STAGES-1:0]          col_vld;
  logic [STAGES-1:0]          col_desc;
  logic                       adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = stage_vld[STAGES-1];
  assign out_desc  = stage_desc[STAGES-1];
  assign out_data  = stage_dat[STAGES-1];

  // Column s reads from the input port (s = 0) or from the register after column s-1.
  for (genvar s = 0; s < STAGES; s++) begin : g_col_src
    if (s == 0) begin : g_first
      assign col_in[s]   = in_data;
      assign col_vld[s]  = in_valid;
      assign col_desc[s] = in_desc;
    end else begin : g_next
      assign col_in[s]   = stage_dat[s-1];
      assign col_vld[s]  = stage_vld[s-1];
      assign col_desc[s] = stage_desc[s-1];
    end
  end

  for (genvar kk = 1; kk <= LOG_N; kk++) begin : g_merge
    for (genvar jd = 0; jd < kk; jd++) begin : g_dist
      localparam int JL = kk - 1 - jd;
      localparam int S  = stages(kk - 1) + jd;
      for (genvar q = 0; q < N/2; q++) begin : g_pair
        localparam int LO = pair_lo(q, JL);
        localparam int HI = partner(LO, 1 << JL);
        sort_cas #(.W(W)) u_cas (
          .a         (col_in[S][LO*W +: W]),
          .b         (col_in[S][HI*W +: W]),
          .asc       (pair_asc(LO, 1 << kk, kk == LOG_N, col_desc[S])),
          .is_signed (SIGNED != 0),
          .lo        (col_out[S][LO*W +: W]),
          .hi        (col_out[S][HI*W +: W])
        );
      end
    end
  end

  // Bubbles shift like real vectors so timing never depends on the input pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_dat  <= '0;
      stage_vld  <= '0;
      stage_desc <= '0;
    end else if (adv) begin
      stage_dat  <= col_out;
      stage_vld  <= col_vld;
      stage_desc <= col_desc;
    end
  end

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
// Bench for bitonic_sort_pipe: default 8x3 unsigned instance plus a 16x8 signed instance.
// A sorting reference model feeds per-instance scoreboards checked every negedge.
module tb_bitonic_sort_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic         a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready, a_out_desc;
  logic [23:0]  a_in_data, a_out_data;
  logic         b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready, b_out_desc;
  logic [127:0] b_in_data, b_out_data;

  typedef struct {
    logic [127:0] dat;
    logic         desc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int a_outs = 0;
  int b_outs = 0;

  bitonic_sort_pipe #(.LOG_N(3), .W(3), .SIGNED(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_desc(a_in_desc), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_desc(a_out_desc), .out_data(a_out_data)
  );

  bitonic_sort_pipe #(.LOG_N(4), .W(8), .SIGNED(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_desc(b_in_desc), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_desc(b_out_desc), .out_data(b_out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain selection sort on decoded integers, then reverse for descending.
  function automatic logic [127:0] model_sort(input logic [127:0] v, input int n, input int w,
                                              input bit sgn, input bit desc);
    longint e[16];
    longint t;
    logic [127:0] mask;
    logic [127:0] r;
    int slot;
    mask = (128'd1 << w) - 128'd1;
    r = '0;
    for (int i = 0; i < n; i++) begin
      e[i] = longint'((v >> (i * w)) & mask);
      if (sgn && e[i] >= (longint'(1) << (w - 1))) e[i] = e[i] - (longint'(1) << w);
    end
    for (int i = 0; i < n; i++)
      for (int k = i + 1; k < n; k++)
        if (e[k] < e[i]) begin
          t = e[i]; e[i] = e[k]; e[k] = t;
        end
    for (int i = 0; i < n; i++) begin
      slot = desc ? (n - 1 - i) : i;
      r = r | ((128'(e[i]) & mask) << (slot * w));
    end
    return r;
  endfunction

  logic         a_hold, b_hold;
  logic [127:0] a_hold_dat, b_hold_dat;
  logic         a_hold_desc, b_hold_desc;
  exp_t         ea, eb;

  always @(negedge clk) begin
    if (!reset) begin
      qa.delete();
      qb.delete();
      a_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (a_hold) begin
        chk("a_hold_valid", 128'(a_out_valid), 128'd1);
        chk("a_hold_data", 128'(a_out_data), a_hold_dat);
        chk("a_hold_desc", 128'(a_out_desc), 128'(a_hold_desc));
      end
      if (b_hold) begin
        chk("b_hold_data", b_out_data, b_hold_dat);
        chk("b_hold_desc", 128'(b_out_desc), 128'(b_hold_desc));
      end
      a_hold = a_out_valid && !a_out_ready;
      a_hold_dat = 128'(a_out_data);
      a_hold_desc = a_out_desc;
      b_hold = b_out_valid && !b_out_ready;
      b_hold_dat = b_out_data;
      b_hold_desc = b_out_desc;
      if (a_out_valid) chk("a_in_ready_eq_out_ready", 128'(a_in_ready), 128'(a_out_ready));
      if (b_out_valid) chk("b_in_ready_eq_out_ready", 128'(b_in_ready), 128'(b_out_ready));
      if (a_out_valid && a_out_ready) begin
        a_outs++;
        if (qa.size() == 0) chk("a_unexpected_output", 128'd1, 128'd0);
        else begin
          ea = qa.pop_front();
          chk("a_sorted_data", 128'(a_out_data), ea.dat);
          chk("a_sorted_desc", 128'(a_out_desc), 128'(ea.desc));
        end
      end
      if (b_out_valid && b_out_ready) begin
        b_outs++;
        if (qb.size() == 0) chk("b_unexpected_output", 128'd1, 128'd0);
        else begin
          eb = qb.pop_front();
          chk("b_sorted_data", b_out_data, eb.dat);
          chk("b_sorted_desc", 128'(b_out_desc), 128'(eb.desc));
        end
      end
      if (a_in_valid && a_in_ready) begin
        ea.dat = model_sort(128'(a_in_data), 8, 3, 1'b0, a_in_desc);
        ea.desc = a_in_desc;
        qa.push_back(ea);
      end
      if (b_in_valid && b_in_ready) begin
        eb.dat = model_sort(b_in_data, 16, 8, 1'b1, b_in_desc);
        eb.desc = b_in_desc;
        qb.push_back(eb);
      end
    end
  end

  // Sends one vector to instance A, returns edges-after-accept until out_valid, then consumes it.
  task automatic run_a(input logic [23:0] d, input logic ds, output int lat,
                       output logic [23:0] od, output logic odesc);
    @(posedge clk); #1;
    a_in_data = d; a_in_desc = ds; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    od = a_out_data;
    odesc = a_out_desc;
    @(posedge clk); #1;
  endtask

  task automatic run_b(input logic [127:0] d, input logic ds, output int lat,
                       output logic [127:0] od);
    @(posedge clk); #1;
    b_in_data = d; b_in_desc = ds; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    od = b_out_data;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [23:0] od;
    logic odesc;
    logic [127:0] bod;
    logic [127:0] bvec;
    int sent;
    int cyc;
    int start_outs;
    bit acc;

    a_in_valid = 1'b0; a_in_desc = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_desc = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(a_out_valid), 128'd0);
    chk("reset_out_data", 128'(a_out_data), 128'd0);
    chk("reset_out_desc", 128'(a_out_desc), 128'd0);
    chk("reset_in_ready", 128'(a_in_ready), 128'd1);
    chk("reset_b_out_valid", 128'(b_out_valid), 128'd0);
    reset = 1'b1;

    chk("model_pin_asc", model_sort(128'h053977, 8, 3, 1'b0, 1'b0), 128'hFAC688);
    chk("model_pin_desc", model_sort(128'hFAC688, 8, 3, 1'b0, 1'b1), 128'h053977);

    run_a(24'h053977, 1'b0, lat, od, odesc);
    chk("rev_latency", 128'(lat), 128'd5);
    chk("rev_data", 128'(od), 128'hFAC688);
    chk("rev_desc", 128'(odesc), 128'd0);

    run_a(24'hFAC688, 1'b1, lat, od, odesc);
    chk("desc_latency", 128'(lat), 128'd5);
    chk("desc_data", 128'(od), 128'h053977);
    chk("desc_desc", 128'(odesc), 128'd1);

    run_a(24'hB6DB6D, 1'b0, lat, od, odesc);
    chk("all_equal_data", 128'(od), 128'hB6DB6D);

    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk); #1;
          a_in_valid = 1'b1;
          a_in_data = 24'($urandom);
          a_in_desc = 1'($urandom);
          chk("b2b_in_ready", 128'(a_in_ready), 128'd1);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
      end
      begin
        int w;
        int run;
        w = 0;
        @(negedge clk);
        while (!a_out_valid && w < 60) begin
          @(negedge clk);
          w++;
        end
        run = 0;
        while (a_out_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
        chk("b2b_consecutive_outputs", 128'(run), 128'd20);
      end
    join

    sent = 0; cyc = 0; acc = 1'b0;
    start_outs = a_outs;
    while (cyc < 300 && (sent < 10 || a_outs - start_outs < 10)) begin
      @(posedge clk); #1;
      if (acc) a_in_valid = 1'b0;
      a_out_ready = (cyc % 3 == 0);
      cyc++;
      if (!a_in_valid && sent < 10) begin
        a_in_valid = 1'b1;
        a_in_data = 24'($urandom);
        a_in_desc = 1'($urandom);
      end
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      if (acc) sent++;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    chk("bp_output_count", 128'(a_outs - start_outs), 128'd10);

    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data = 24'($urandom);
      a_in_desc = 1'b0;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("midreset_out_valid", 128'(a_out_valid), 128'd0);
    chk("midreset_out_data", 128'(a_out_data), 128'd0);
    chk("midreset_in_ready", 128'(a_in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_a(24'h2C5A3F, 1'b0, lat, od, odesc);
    chk("postreset_latency", 128'(lat), 128'd5);
    chk("postreset_data", 128'(od), model_sort(128'h2C5A3F, 8, 3, 1'b0, 1'b0));

    bvec = {$urandom, $urandom, $urandom, $urandom};
    bvec[31:0] = 32'hFF80007F;
    run_b(bvec, 1'b0, lat, bod);
    chk("signed_latency", 128'(lat), 128'd9);
    chk("signed_elem0_min", 128'(bod[7:0]), 128'h80);
    chk("signed_elem15_max", 128'(bod[127:120]), 128'h7F);

    run_b(bvec, 1'b1, lat, bod);
    chk("signed_desc_elem0", 128'(bod[7:0]), 128'h7F);
    chk("signed_desc_elem15", 128'(bod[127:120]), 128'h80);

    repeat (15) @(posedge clk);
    #1;
    chk("a_scoreboard_drained", 128'(qa.size()), 128'd0);
    chk("b_scoreboard_drained", 128'(qb.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
- Parametrised, fully pipelined bitonic sorting network that sorts N = 2**LOG_N elements of W bits each.
- Accepts one vector per cycle, with a per-vector ascending/descending mode.
- valid/ready handshake on both sides; global stall on output backpressure.
- Next generation of the team's fixed 8x3-bit sorter; sits between the capture buffer and the readout/min-max logic.

Parameters:
- LOG_N, 3, log2 of element count; N = 2**LOG_N; legal range 1..5.
- W, 3, element width in bits; legal range 1..32.
- SIGNED, 0, 1 = compare as two's complement; 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0); release synchronised externally.
- in_valid  in  1  input vector present.
- in_ready  out  1  block accepts input this cycle.
- in_desc  in  1  0 = ascending, 1 = descending; captured with the vector.
- in_data  in  N*W  packed elements; element i at bits [i*W +: W].
- out_valid  out  1  sorted vector present.
- out_ready  in  1  downstream accepts output.
- out_desc  out  1  mode bit that travelled with the vector.
- out_data  out  N*W  sorted elements, same packing as in_data.

Behaviour:
- Network depth: STAGES = LOG_N*(LOG_N+1)/2 compare-exchange columns (6 for N=8). Each column is followed by one register stage; no other registers exist.
- Network structure (standard bitonic):
  - For merge size k = 2, 4, ..., N and distance j = k/2 down to 1, element i pairs with partner p = i XOR j, for i < p only.
  - Pair direction is ascending (min to the lower index) when (i AND k) == 0, otherwise descending.
  - In the final merge (k = N) every pair is ascending.
  - If the vector's desc bit is set, every final-merge (k = N) pair is reversed. Earlier merges are unchanged.
- Result: out_data element 0 holds the minimum for ascending, the maximum for descending.
- Comparison: SIGNED selects signed/unsigned. Ties pass through without swap; stability is not required. The output multiset equals the input multiset.
- Handshake:
  - Pipeline enable: adv = !out_valid || out_ready; in_ready = adv (combinational).
  - Transfer on in_valid && in_ready. On adv, all stage registers and their valid/desc bits shift by one stage.
  - When in_valid is 0, a bubble (valid = 0) enters. Bubbles are not collapsed.
  - When adv = 0, all stages hold.
- Latency: a vector accepted at edge t appears on out_valid/out_data after edge t+STAGES-1, provided there is no stall. Throughput is 1 vector/cycle.
- Output hold: out_data/out_desc remain stable while out_valid && !out_ready.
- Reset (reset = 0):
  - All valid bits clear immediately and asynchronously; out_valid = 0.
  - out_data = 0, out_desc = 0, all stage data registers = 0.
  - in_ready = 1 while reset is asserted.
  - Reset mid-operation discards all in-flight vectors; nothing is replayed.
- Boundary cases:
  - Simultaneous accept and output while stalled-then-released: both occur on the same edge; no loss, no duplication.
  - LOG_N = 1 degenerates to a single compare-exchange column; latency is 1.
  - All-equal input returns the same values.

Decomposition:
- sort_pkg holds:
  - function stages(log_n);
  - function partner(i, j);
  - function pair_asc(i, k, final_merge, desc);
  - localparam conventions for element packing.
- Sub-module sort_cas: combinational compare-and-swap of two W-bit operands, with asc and signed controls. Generate loops instantiate N/2 of these per column.
- Column registers and the valid/desc shift live in bitonic_sort_pipe.

Test Plan (defaults N=8, W=3, SIGNED=0 unless noted):
- Reverse order: in_data=24'h053977 (e0..e7 = 7..0), desc=0, out_ready=1 -> out_valid 6 cycles later, out_data=24'hFAC688 (e0..e7 = 0..7), out_desc=0.
- Descending mode: in_data=24'hFAC688, desc=1 -> out_data=24'h053977, out_desc=1.
- Back-to-back: 20 random vectors on consecutive cycles, out_ready=1 -> 20 outputs on consecutive cycles, in order, each matching a reference sort; in_ready stays 1.
- Backpressure: stream 10 vectors while out_ready toggles 1,0,0,1,... -> no drop/duplication. out_data is stable during the 0 cycles; in_ready equals out_ready whenever out_valid = 1.
- Reset mid-stream: assert reset=0 with 4 vectors in flight -> out_valid=0 and out_data=0 immediately. After release the first new vector emerges at latency 6, with no stale data.
- Signed, wide: LOG_N=4, W=8, SIGNED=1, input containing 8'h80, 8'h7F, 8'hFF, 8'h00 plus 12 random values -> element0=8'h80, element15=8'h7F, with full order checked against the model.
